multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle RV32I core. It sequences the shared ALU, memory port, register file and PC through fetch, decode, execute, memory and write-back steps. It drives `alu_op` into `alu_decoder` (3-bit instruction-type encoding) and the datapath mux selects and write enables. It handles a ready-based memory handshake and traps on unsupported opcodes.

---
 rtl/mc_ctrl_pkg.sv | 73 +++++++
 rtl/branch_cond.sv | 22 ++
 rtl/multicycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, the
// alu_op instruction-type code consumed by alu_decoder, opcodes and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_EXEC_U    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR      = 4'd12,
        S_JAL_LINK  = 4'd13,
        S_TRAP      = 4'd14
    } state_e;

    typedef enum logic [2:0] {
        ALU_RIALU  = 3'b000,
        ALU_I      = 3'b001,
        ALU_S      = 3'b010,
        ALU_B      = 3'b011,
        ALU_U      = 3'b100,
        ALU_U_LUI  = 3'b101,
        ALU_J_JALR = 3'b110,
        ALU_J_JAL  = 3'b111
    } alu_op_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        alu_op_e    alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/branch_cond.sv
// Branch outcome for the supported conditional branches (BEQ/BNE); any other
// funct3 is flagged so the FSM can trap instead of branching.
module branch_cond
    import mc_ctrl_pkg::*;
#(
    parameter int F3_WIDTH = 3
) (
    input  logic [F3_WIDTH-1:0] funct3,
    input  logic                zero,
    output logic                take,
    output logic                bad_funct3
);

    logic w_is_beq;
    logic w_is_bne;

    assign w_is_beq   = (funct3 == F3_BEQ);
    assign w_is_bne   = (funct3 == F3_BNE);
    assign take       = (w_is_beq & zero) | (w_is_bne & ~zero);
    assign bad_funct3 = ~(w_is_beq | w_is_bne);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: Moore decode of the datapath
// controls, ready-based memory handshake and a sticky trap on unsupported opcodes.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = 7,
    parameter int F3_WIDTH    = 3,
    parameter int ALUOP_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic [F3_WIDTH-1:0]    funct3,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   mem_write,
    output logic                   adr_src,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   reg_write,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             result_src,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   illegal,
    output logic [3:0]             state
);

    state_e r_state;
    state_e w_next_state;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_out;
    logic   w_take;
    logic   w_bad_funct3;

    branch_cond #(.F3_WIDTH(F3_WIDTH)) u_branch_cond (
        .funct3     (funct3),
        .zero       (zero),
        .take       (w_take),
        .bad_funct3 (w_bad_funct3)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:     if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OPC_R:                 w_next_state = S_EXEC_R;
                    OPC_I:                 w_next_state = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:   w_next_state = S_MEM_ADDR;
                    OPC_BRANCH:            w_next_state = S_BRANCH;
                    OPC_JAL:               w_next_state = S_JAL;
                    OPC_JALR:              w_next_state = S_JALR;
                    OPC_LUI, OPC_AUIPC:    w_next_state = S_EXEC_U;
                    default:               w_next_state = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_U, S_JAL, S_JAL_LINK:
                         w_next_state = S_ALU_WB;
            S_MEM_ADDR:  w_next_state = (op == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) w_next_state = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) w_next_state = S_FETCH;
            S_MEM_WB, S_ALU_WB:
                         w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = w_bad_funct3 ? S_TRAP : S_FETCH;
            S_JALR:      w_next_state = S_JAL_LINK;
            S_TRAP:      w_next_state = S_TRAP;
            default:     w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.alu_op     = ALU_I;
                w_ctrl.result_src = RES_ALU;
                w_ctrl.ir_write   = mem_ready;
                w_ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_J_JAL;
            end
            S_EXEC_R: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_op    = ALU_RIALU;
            end
            S_EXEC_I: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_RIALU;
            end
            S_EXEC_U: begin
                w_ctrl.alu_src_b = SRCB_IMM;
                if (op == OPC_LUI) begin
                    w_ctrl.alu_src_a = SRCA_RS1;
                    w_ctrl.alu_op    = ALU_U_LUI;
                end else begin
                    w_ctrl.alu_src_a = SRCA_OLDPC;
                    w_ctrl.alu_op    = ALU_U;
                end
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = (op == OPC_STORE) ? ALU_S : ALU_I;
            end
            S_MEM_READ: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.adr_src = 1'b1;
            end
            S_MEM_WB: begin
                w_ctrl.result_src = RES_MEMDATA;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.adr_src   = 1'b1;
            end
            S_ALU_WB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_RS2;
                w_ctrl.alu_op     = ALU_B;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_write   = w_take;
            end
            S_JAL: begin
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.alu_op     = ALU_J_JAL;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_write   = 1'b1;
            end
            S_JALR: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.alu_op     = ALU_J_JALR;
                w_ctrl.result_src = RES_ALU;
                w_ctrl.pc_write   = 1'b1;
            end
            S_JAL_LINK: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALU_J_JAL;
            end
            S_TRAP:  w_ctrl.illegal = 1'b1;
            default: w_ctrl = '0;
        endcase
    end

    // Reset forces every output low at once, dropping any in-flight memory request.
    assign w_ctrl_out = rst ? '0 : w_ctrl;

    assign mem_req    = w_ctrl_out.mem_req;
    assign mem_write  = w_ctrl_out.mem_write;
    assign adr_src    = w_ctrl_out.adr_src;
    assign ir_write   = w_ctrl_out.ir_write;
    assign pc_write   = w_ctrl_out.pc_write;
    assign reg_write  = w_ctrl_out.reg_write;
    assign alu_src_a  = w_ctrl_out.alu_src_a;
    assign alu_src_b  = w_ctrl_out.alu_src_b;
    assign result_src = w_ctrl_out.result_src;
    assign alu_op     = ALUOP_WIDTH'(w_ctrl_out.alu_op);
    assign illegal    = w_ctrl_out.illegal;
    assign state      = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases from the control
// sequence rules plus randomized instructions against a per-instruction step model.
module tb_multicycle_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    // Opcode values written out independently of the design package.
    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_op, illegal};

    typedef struct {
        logic        ready;
        logic [19:0] v;
        string       tag;
    } step_t;

    step_t q[$];

    function automatic logic [19:0] ov(input logic [3:0] st, input logic mreq, input logic mwr,
                                       input logic adr, input logic irw, input logic pcw,
                                       input logic rw, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic [2:0] aop,
                                       input logic ill);
        return {st, mreq, mwr, adr, irw, pcw, rw, a, b, res, aop, ill};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [6:0] o);
        return o inside {T_R, T_I, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC};
    endfunction

    task automatic push(input logic rdy, input logic [19:0] v, input string tag);
        step_t s;
        s.ready = rdy;
        s.v     = v;
        s.tag   = tag;
        q.push_back(s);
    endtask

    task automatic push_alu_wb();
        push(rnd(), ov(S_ALU_WB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0), "alu_wb");
    endtask

    task automatic push_trap();
        for (int i = 0; i < 3; i++)
            push(rnd(), ov(S_TRAP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1), "trap");
    endtask

    // Expected cycle-by-cycle controls of one instruction; returns 1 when it traps.
    task automatic model_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                               input int fw, input int mw, output logic trapped);
        trapped = 1'b0;
        for (int i = 0; i < fw; i++)
            push(1'b0, ov(S_FETCH, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b001, 0), "fetch_wait");
        push(1'b1, ov(S_FETCH, 1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'b001, 0), "fetch");
        push(rnd(), ov(S_DECODE, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b111, 0), "decode");
        case (o)
            T_R: begin
                push(rnd(), ov(S_EXEC_R, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 0), "exec_r");
                push_alu_wb();
            end
            T_I: begin
                push(rnd(), ov(S_EXEC_I, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 0), "exec_i");
                push_alu_wb();
            end
            T_LUI: begin
                push(rnd(), ov(S_EXEC_U, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b101, 0), "exec_lui");
                push_alu_wb();
            end
            T_AUIPC: begin
                push(rnd(), ov(S_EXEC_U, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b100, 0), "exec_auipc");
                push_alu_wb();
            end
            T_LOAD: begin
                push(rnd(), ov(S_MEM_ADDR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 0), "addr_ld");
                for (int i = 0; i <= mw; i++)
                    push(i == mw, ov(S_MEM_READ, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0), "mem_read");
                push(rnd(), ov(S_MEM_WB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 0), "mem_wb");
            end
            T_STORE: begin
                push(rnd(), ov(S_MEM_ADDR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b010, 0), "addr_st");
                for (int i = 0; i <= mw; i++)
                    push(i == mw, ov(S_MEM_WRITE, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0), "mem_write");
            end
            T_BRANCH: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    push(rnd(), ov(S_BRANCH, 0, 0, 0, 0, (f3 == 3'b000) ? z : !z, 0,
                                   2'b10, 2'b00, 2'b00, 3'b011, 0), "branch");
                end else begin
                    push(rnd(), ov(S_BRANCH, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b011, 0), "branch_bad");
                    push_trap();
                    trapped = 1'b1;
                end
            end
            T_JAL: begin
                push(rnd(), ov(S_JAL, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b111, 0), "jal");
                push_alu_wb();
            end
            T_JALR: begin
                push(rnd(), ov(S_JALR, 0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 3'b110, 0), "jalr");
                push(rnd(), ov(S_JAL_LINK, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b111, 0), "jal_link");
                push_alu_wb();
            end
            default: begin
                push_trap();
                trapped = 1'b1;
            end
        endcase
    endtask

    task automatic check(input logic [19:0] observed, input logic [19:0] expected, input string tag);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Plays the queued steps, one per clock, comparing mid-cycle.
    task automatic run_queue(input logic [6:0] o, input logic [2:0] f3, input logic z);
        step_t s;
        bit    first = 1'b1;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            if (first) begin
                op     = o;
                funct3 = f3;
                zero   = z;
                first  = 1'b0;
            end
            mem_ready = s.ready;
            #2;
            check(obs, s.v, s.tag);
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                             input int fw, input int mw, output logic trapped);
        model_instr(o, f3, z, fw, mw, trapped);
        run_queue(o, f3, z);
    endtask

    // Two cycles in reset with all outputs low, released just after a clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = rnd();
        #2;
        check(obs, 20'h0, "reset_a");
        @(negedge clk);
        mem_ready = rnd();
        #2;
        check(obs, 20'h0, "reset_b");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic       tr;
        logic [6:0] ro;
        logic [2:0] rf3;
        int         pick;

        do_reset();
        run_instr(T_R, 3'b000, 1'b0, 0, 0, tr);
        run_instr(T_LOAD, 3'b010, 1'b0, 0, 2, tr);
        run_instr(T_BRANCH, 3'b000, 1'b1, 0, 0, tr);
        run_instr(T_BRANCH, 3'b000, 1'b0, 1, 0, tr);
        run_instr(T_BRANCH, 3'b001, 1'b1, 0, 0, tr);
        run_instr(T_BRANCH, 3'b001, 1'b0, 0, 0, tr);
        run_instr(T_JALR, 3'b000, 1'b0, 0, 0, tr);
        run_instr(T_JAL, 3'b000, 1'b1, 0, 0, tr);
        run_instr(T_STORE, 3'b010, 1'b0, 0, 1, tr);
        run_instr(T_BRANCH, 3'b100, 1'b1, 0, 0, tr);
        do_reset();
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, tr);
        do_reset();

        // Store stalled in MEM_WRITE, then reset mid-handshake.
        model_instr(T_STORE, 3'b010, 1'b0, 0, 2, tr);
        void'(q.pop_back());
        void'(q.pop_back());
        run_queue(T_STORE, 3'b010, 1'b0);
        do_reset();
        run_instr(T_I, 3'b000, 1'b0, 0, 0, tr);

        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 9);
            rf3  = 3'($urandom_range(0, 7));
            case (pick)
                0: ro = T_R;
                1: ro = T_I;
                2: ro = T_LOAD;
                3: ro = T_STORE;
                4: begin
                    ro = T_BRANCH;
                    if ($urandom_range(0, 3) != 0) rf3 = {2'b00, rnd()};
                end
                5: ro = T_JAL;
                6: ro = T_JALR;
                7: ro = T_LUI;
                8: ro = T_AUIPC;
                default: begin
                    ro = 7'($urandom);
                    while (is_legal(ro)) ro = 7'($urandom);
                end
            endcase
            run_instr(ro, rf3, rnd(), $urandom_range(0, 2), $urandom_range(0, 2), tr);
            if (tr) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
